// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: FSM encoding, counter widths, VGA defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Also used by the output timing generator so both sides agree on encodings.
package video_timing_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } vt_state_t;

  localparam int CNT_W = 12;
  localparam int COL_W = 10;
  localparam int ROW_W = 9;

  localparam int DEF_HTOTAL = 800;
  localparam int DEF_HACT   = 640;
  localparam int DEF_VTOTAL = 525;
  localparam int DEF_VACT   = 480;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/video_timing_detect_sync_edge_det.sv
// Polarity-normalising input register with a registered rising-edge pulse.
// Latency: lvl1 1 clock, lvl2 and rise 2 clocks from the raw input.
// Backpressure: none; free-running every clock.
// Ports: I_PCLK/I_RST clock and sync reset; raw input sample;
//        lvl1 stage-1 level (active-high), lvl2 stage-2 level, rise stage-2 pulse.
module sync_edge_det #(
  parameter bit POL = 1'b1
) (
  input  logic I_PCLK,
  input  logic I_RST,
  input  logic raw,
  output logic lvl1,
  output logic lvl2,
  output logic rise
);

  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      lvl1 <= 1'b0;
      lvl2 <= 1'b0;
      rise <= 1'b0;
    end else begin
      // XOR with the inverted polarity makes the asserted level read as 1.
      lvl1 <= raw ^ ~POL;
      lvl2 <= lvl1;
      rise <= lvl1 & ~lvl2;
    end
  end

endmodule

// File: rtl/video_timing_detect.sv
// Sync-stream decoder: recovers pixel column/row, measures geometry, declares lock.
// Latency: 2 clocks input to O_DE/O_PIXEL_*/O_*_START; measurements 1 clock later.
// Backpressure: none; consumes one pixel per clock unconditionally.
// Ports: I_PCLK, I_RST (sync, active-high); I_VSYNC/I_HSYNC/I_DE raw inputs;
//        O_DE/O_PIXEL_COLUMN/O_PIXEL_ROW aligned pixel position; O_FRAME_START,
//        O_LINE_START edge pulses; O_HTOTAL/O_HACT/O_VTOTAL/O_VACT geometry;
//        O_LOCKED lock status; O_ERR pulse on lock loss or missing HS.
module video_timing_detect
  import video_timing_pkg::*;
#(
  parameter int VGA_HTOTAL = DEF_HTOTAL,
  parameter int VGA_HACT   = DEF_HACT,
  parameter int VGA_VTOTAL = DEF_VTOTAL,
  parameter int VGA_VACT   = DEF_VACT,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1
) (
  input  logic             I_PCLK,
  input  logic             I_RST,
  input  logic             I_VSYNC,
  input  logic             I_HSYNC,
  input  logic             I_DE,
  output logic             O_DE,
  output logic [COL_W-1:0] O_PIXEL_COLUMN,
  output logic [ROW_W-1:0] O_PIXEL_ROW,
  output logic             O_FRAME_START,
  output logic             O_LINE_START,
  output logic [CNT_W-1:0] O_HTOTAL,
  output logic [CNT_W-1:0] O_HACT,
  output logic [CNT_W-1:0] O_VTOTAL,
  output logic [CNT_W-1:0] O_VACT,
  output logic             O_LOCKED,
  output logic             O_ERR
);

  localparam logic [CNT_W-1:0] EXP_HTOTAL = CNT_W'(VGA_HTOTAL);
  localparam logic [CNT_W-1:0] EXP_HACT   = CNT_W'(VGA_HACT);
  localparam logic [CNT_W-1:0] EXP_VTOTAL = CNT_W'(VGA_VTOTAL);
  localparam logic [CNT_W-1:0] EXP_VACT   = CNT_W'(VGA_VACT);
  localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);

  logic hs_lvl1, hs_lvl2, hs_rise;
  logic vs_lvl1, vs_lvl2, vs_rise;
  logic de_lvl1, de_lvl2, de_rise;

  sync_edge_det #(.POL(HS_POL)) u_hs (
    .I_PCLK (I_PCLK), .I_RST (I_RST), .raw (I_HSYNC),
    .lvl1   (hs_lvl1), .lvl2 (hs_lvl2), .rise (hs_rise)
  );
  sync_edge_det #(.POL(VS_POL)) u_vs (
    .I_PCLK (I_PCLK), .I_RST (I_RST), .raw (I_VSYNC),
    .lvl1   (vs_lvl1), .lvl2 (vs_lvl2), .rise (vs_rise)
  );
  sync_edge_det #(.POL(1'b1)) u_de (
    .I_PCLK (I_PCLK), .I_RST (I_RST), .raw (I_DE),
    .lvl1   (de_lvl1), .lvl2 (de_lvl2), .rise (de_rise)
  );

  // HS stage levels are not needed; only its registered edge pulse is used.
  logic unused_hs_lvl;
  assign unused_hs_lvl = hs_lvl1 ^ hs_lvl2;

  assign O_DE          = de_lvl2;
  assign O_FRAME_START = vs_rise;
  assign O_LINE_START  = hs_rise;

  // Pixel position is updated from stage-1 edges so it lands with O_DE.
  logic de_rise1, vs_rise1;
  assign de_rise1 = de_lvl1 & ~de_lvl2;
  assign vs_rise1 = vs_lvl1 & ~vs_lvl2;

  logic de_prev, de_fall;
  assign de_fall = de_prev & ~de_lvl2;

  logic [CNT_W-1:0] h_cnt, hact_cnt, v_cnt, vact_cnt;
  logic             hs_seen, row_first;

  // Next values of the measurement registers; lock decisions use these so
  // a VS edge is judged on the values latched by that same edge.
  logic [CNT_W-1:0] htotal_nxt, hact_nxt, vtotal_nxt, vact_nxt;
  logic             match, h_sat;

  always_comb begin
    htotal_nxt = O_HTOTAL;
    if (hs_rise && hs_seen) htotal_nxt = sat_inc(h_cnt);
    hact_nxt = de_fall ? hact_cnt : O_HACT;
    vtotal_nxt = O_VTOTAL;
    // A coincident HS edge belongs to the frame that is closing.
    if (vs_rise) vtotal_nxt = hs_rise ? sat_inc(v_cnt) : v_cnt;
    vact_nxt = vs_rise ? vact_cnt : O_VACT;
  end

  assign match = (htotal_nxt == EXP_HTOTAL) && (hact_nxt == EXP_HACT) &&
                 (vtotal_nxt == EXP_VTOTAL) && (vact_nxt == EXP_VACT);

  // Single-cycle event: h_cnt is about to reach its ceiling (HS missing).
  assign h_sat = !hs_rise && (h_cnt == CNT_PRE);

  vt_state_t state, state_nxt;
  logic      err_nxt;

  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      state    <= SEARCH;
      O_LOCKED <= 1'b0;
      O_ERR    <= 1'b0;
    end else begin
      state    <= state_nxt;
      O_LOCKED <= (state_nxt == LOCKED);
      O_ERR    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    if (h_sat) begin
      state_nxt = SEARCH;
      err_nxt   = 1'b1;
    end else if (vs_rise) begin
      case (state)
        SEARCH:  state_nxt = MEASURE;
        MEASURE: state_nxt = match ? VERIFY : SEARCH;
        VERIFY:  state_nxt = match ? LOCKED : SEARCH;
        LOCKED: begin
          if (!match) begin
            state_nxt = SEARCH;
            err_nxt   = 1'b1;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      h_cnt          <= '0;
      hact_cnt       <= '0;
      v_cnt          <= '0;
      vact_cnt       <= '0;
      hs_seen        <= 1'b0;
      de_prev        <= 1'b0;
      row_first      <= 1'b1;
      O_HTOTAL       <= '0;
      O_HACT         <= '0;
      O_VTOTAL       <= '0;
      O_VACT         <= '0;
      O_PIXEL_COLUMN <= '0;
      O_PIXEL_ROW    <= '0;
    end else begin
      if (hs_rise) begin
        h_cnt   <= '0;
        hs_seen <= 1'b1;
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end

      if (de_fall)      hact_cnt <= '0;
      else if (de_lvl2) hact_cnt <= sat_inc(hact_cnt);

      if (vs_rise)      v_cnt <= '0;
      else if (hs_rise) v_cnt <= sat_inc(v_cnt);

      if (vs_rise)      vact_cnt <= '0;
      else if (de_rise) vact_cnt <= sat_inc(vact_cnt);

      de_prev  <= de_lvl2;
      O_HTOTAL <= htotal_nxt;
      O_HACT   <= hact_nxt;
      O_VTOTAL <= vtotal_nxt;
      O_VACT   <= vact_nxt;

      // Column wraps freely; it restarts at every DE rising edge anyway.
      if (de_rise1)     O_PIXEL_COLUMN <= '0;
      else if (de_lvl1) O_PIXEL_COLUMN <= O_PIXEL_COLUMN + COL_ONE;

      // First active line after VS stays at row 0.
      if (vs_rise1) begin
        O_PIXEL_ROW <= '0;
        row_first   <= 1'b1;
      end else if (de_rise1) begin
        if (row_first) row_first   <= 1'b0;
        else           O_PIXEL_ROW <= O_PIXEL_ROW + ROW_ONE;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_detect.sv
// Bench for video_timing_detect with a scaled-down geometry (40x12 total, 24x8 active).
// A positive-polarity and a negative-polarity instance are driven by the same
// stream (syncs inverted for the latter) and both must meet the same expectations.
module tb_video_timing_detect;

  localparam int HT = 40;
  localparam int HA = 24;
  localparam int VT = 12;
  localparam int VA = 8;

  typedef struct packed {
    int nlines; int hact; int lck; int ht; int ha; int vt; int va; int err; int col; int row;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hsync = 1'b0;
  logic vsync = 1'b0;
  logic de = 1'b0;

  always #5 clk = ~clk;

  logic p_de, p_fs, p_ls, p_lck, p_err;
  logic [9:0] p_col;
  logic [8:0] p_row;
  logic [11:0] p_ht, p_ha, p_vt, p_va;
  logic n_de, n_fs, n_ls, n_lck, n_err;
  logic [9:0] n_col;
  logic [8:0] n_row;
  logic [11:0] n_ht, n_ha, n_vt, n_va;

  video_timing_detect #(
    .VGA_HTOTAL(HT), .VGA_HACT(HA), .VGA_VTOTAL(VT), .VGA_VACT(VA),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .I_PCLK(clk), .I_RST(rst), .I_VSYNC(vsync), .I_HSYNC(hsync), .I_DE(de),
    .O_DE(p_de), .O_PIXEL_COLUMN(p_col), .O_PIXEL_ROW(p_row),
    .O_FRAME_START(p_fs), .O_LINE_START(p_ls),
    .O_HTOTAL(p_ht), .O_HACT(p_ha), .O_VTOTAL(p_vt), .O_VACT(p_va),
    .O_LOCKED(p_lck), .O_ERR(p_err)
  );

  video_timing_detect #(
    .VGA_HTOTAL(HT), .VGA_HACT(HA), .VGA_VTOTAL(VT), .VGA_VACT(VA),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .I_PCLK(clk), .I_RST(rst), .I_VSYNC(~vsync), .I_HSYNC(~hsync), .I_DE(de),
    .O_DE(n_de), .O_PIXEL_COLUMN(n_col), .O_PIXEL_ROW(n_row),
    .O_FRAME_START(n_fs), .O_LINE_START(n_ls),
    .O_HTOTAL(n_ht), .O_HACT(n_ha), .O_VTOTAL(n_vt), .O_VACT(n_va),
    .O_LOCKED(n_lck), .O_ERR(n_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Running event counts and last active pixel seen, per instance.
  int err_p = 0, err_n = 0, fs_p = 0, fs_n = 0, ls_p = 0, ls_n = 0;
  int lcol_p = 0, lrow_p = 0, lcol_n = 0, lrow_n = 0;

  always @(negedge clk) begin
    if (p_err) err_p++;
    if (n_err) err_n++;
    if (p_fs) fs_p++;
    if (n_fs) fs_n++;
    if (p_ls) ls_p++;
    if (n_ls) ls_n++;
    if (p_de) begin lcol_p = int'(p_col); lrow_p = int'(p_row); end
    if (n_de) begin lcol_n = int'(n_col); lrow_n = int'(n_row); end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic hs, input logic vs, input logic d);
    hsync = hs;
    vsync = vs;
    de    = d;
    @(posedge clk);
    #1;
  endtask

  // Frame layout: VS on lines 0-1 (leading edge coincides with HS),
  // HS on h 0-3, DE on lines 3..3+VA-1 for h 8..8+hact-1.
  task automatic drive_span(input int nlines, input int hact, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      int l = c / HT;
      int h = c % HT;
      if (l < nlines)
        tick(h < 4, l < 2, (l >= 3) && (l < 3 + VA) && (h >= 8) && (h < 8 + hact));
    end
  endtask

  task automatic drive_frame(input int nlines, input int hact);
    drive_span(nlines, hact, 0, nlines * HT - 1);
  endtask

  task automatic chk_frame(input string tag, input vec_t e, input int lk, input int ht,
                           input int ha, input int vt, input int va, input int er,
                           input int fs, input int ls, input int cl, input int rw);
    chk({tag, ".locked"}, lk, e.lck);
    chk({tag, ".htotal"}, ht, e.ht);
    chk({tag, ".hact"},   ha, e.ha);
    chk({tag, ".vtotal"}, vt, e.vt);
    chk({tag, ".vact"},   va, e.va);
    chk({tag, ".err"},    er, e.err);
    chk({tag, ".fstart"}, fs, 1);
    chk({tag, ".lstart"}, ls, e.nlines);
    chk({tag, ".lastcol"}, cl, e.col);
    chk({tag, ".lastrow"}, rw, e.row);
  endtask

  vec_t tab [18];

  initial begin
    int e0p, e0n, f0p, f0n, l0p, l0n;

    //             lines hact lck  ht  ha  vt va err col row
    tab[0]  = '{   12,   24,   0,  40, 24,  1, 0, 0, 23, 7};
    tab[1]  = '{   12,   24,   0,  40, 24, 12, 8, 0, 23, 7};
    tab[2]  = '{   12,   24,   1,  40, 24, 12, 8, 0, 23, 7};
    tab[3]  = '{   12,   24,   1,  40, 24, 12, 8, 0, 23, 7};
    tab[4]  = '{   11,   24,   1,  40, 24, 12, 8, 0, 23, 7};
    tab[5]  = '{   12,   24,   0,  40, 24, 11, 8, 1, 23, 7};
    tab[6]  = '{   12,   24,   0,  40, 24, 12, 8, 0, 23, 7};
    tab[7]  = '{   12,   24,   0,  40, 24, 12, 8, 0, 23, 7};
    tab[8]  = '{   12,   24,   1,  40, 24, 12, 8, 0, 23, 7};
    tab[9]  = '{   12,   23,   1,  40, 23, 12, 8, 0, 22, 7};
    tab[10] = '{   12,   23,   0,  40, 23, 12, 8, 1, 22, 7};
    tab[11] = '{   12,   23,   0,  40, 23, 12, 8, 0, 22, 7};
    tab[12] = '{   12,   23,   0,  40, 23, 12, 8, 0, 22, 7};
    tab[13] = '{   12,   23,   0,  40, 23, 12, 8, 0, 22, 7};
    tab[14] = '{   12,   23,   0,  40, 23, 12, 8, 0, 22, 7};
    tab[15] = '{   12,   24,   0,  40, 24, 12, 8, 0, 23, 7};
    tab[16] = '{   12,   24,   0,  40, 24, 12, 8, 0, 23, 7};
    tab[17] = '{   12,   24,   1,  40, 24, 12, 8, 0, 23, 7};

    rst = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("reset.p.locked", int'(p_lck), 0);
    chk("reset.p.htotal", int'(p_ht), 0);
    chk("reset.p.col",    int'(p_col), 0);
    chk("reset.n.de",     int'(n_de), 0);
    chk("reset.n.vtotal", int'(n_vt), 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      e0p = err_p; e0n = err_n; f0p = fs_p; f0n = fs_n; l0p = ls_p; l0n = ls_n;
      drive_frame(tab[i].nlines, tab[i].hact);
      chk_frame($sformatf("v%0d.p", i), tab[i], int'(p_lck), int'(p_ht), int'(p_ha),
                int'(p_vt), int'(p_va), err_p - e0p, fs_p - f0p, ls_p - l0p, lcol_p, lrow_p);
      chk_frame($sformatf("v%0d.n", i), tab[i], int'(n_lck), int'(n_ht), int'(n_ha),
                int'(n_vt), int'(n_va), err_n - e0n, fs_n - f0n, ls_n - l0n, lcol_n, lrow_n);
    end

    // HS missing while locked: h_cnt saturates once, lock drops, HTOTAL holds.
    e0p = err_p; e0n = err_n;
    repeat (5000) tick(1'b0, 1'b0, 1'b0);
    chk("hold.p.err",    err_p - e0p, 1);
    chk("hold.n.err",    err_n - e0n, 1);
    chk("hold.p.locked", int'(p_lck), 0);
    chk("hold.n.locked", int'(n_lck), 0);
    chk("hold.p.htotal", int'(p_ht), HT);
    chk("hold.n.htotal", int'(n_ht), HT);

    drive_frame(VT, HA);
    drive_frame(VT, HA);
    chk("relock2.p.locked", int'(p_lck), 0);
    chk("relock2.n.locked", int'(n_lck), 0);
    drive_frame(VT, HA);
    chk("relock3.p.locked", int'(p_lck), 1);
    chk("relock3.n.locked", int'(n_lck), 1);

    // One-clock reset in the middle of an active line while locked.
    drive_span(VT, HA, 0, 5 * HT + 19);
    rst = 1'b1;
    drive_span(VT, HA, 5 * HT + 20, 5 * HT + 20);
    rst = 1'b0;
    chk("rst.p.de",     int'(p_de), 0);
    chk("rst.p.col",    int'(p_col), 0);
    chk("rst.p.row",    int'(p_row), 0);
    chk("rst.p.htotal", int'(p_ht), 0);
    chk("rst.p.hact",   int'(p_ha), 0);
    chk("rst.p.vtotal", int'(p_vt), 0);
    chk("rst.p.vact",   int'(p_va), 0);
    chk("rst.p.locked", int'(p_lck), 0);
    chk("rst.n.de",     int'(n_de), 0);
    chk("rst.n.col",    int'(n_col), 0);
    chk("rst.n.htotal", int'(n_ht), 0);
    chk("rst.n.locked", int'(n_lck), 0);
    f0p = fs_p; f0n = fs_n;
    drive_span(VT, HA, 5 * HT + 21, VT * HT - 1);
    chk("rst.p.fs_before_vs", fs_p - f0p, 0);
    chk("rst.n.fs_before_vs", fs_n - f0n, 0);
    f0p = fs_p; f0n = fs_n;
    drive_frame(VT, HA);
    chk("rst.p.fs_first", fs_p - f0p, 1);
    chk("rst.n.fs_first", fs_n - f0n, 1);
    chk("rst1.p.locked", int'(p_lck), 0);
    drive_frame(VT, HA);
    chk("rst2.p.locked", int'(p_lck), 0);
    chk("rst2.n.locked", int'(n_lck), 0);
    drive_frame(VT, HA);
    chk("rst3.p.locked", int'(p_lck), 1);
    chk("rst3.n.locked", int'(n_lck), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_detect.md
# video_timing_detect

Pixel-clock-domain receiver for the incoming VGA-style sync stream (VSYNC/HSYNC/DE) on the camera/input side of the edge-detection pipeline. It recovers active-pixel column and row, measures frame geometry, and declares lock against the expected 640x480 timing. It is the counterpart of the output video timing generator: the generator produces HS/VS/DE, and this block decodes them. Lock status and row/col feed the colorspace/Sobel path and the vsync-aligned restart of the output timing.

## Interface
- VGA_HTOTAL, 800: expected clocks per line.
- VGA_HACT, 640: expected active pixels per line.
- VGA_VTOTAL, 525: expected lines per frame.
- VGA_VACT, 480: expected active lines per frame.
- HS_POL, 1: asserted level of I_HSYNC (1 = active-high).
- VS_POL, 1: asserted level of I_VSYNC.
- I_PCLK  in  1  pixel clock; the only clock.
- I_RST  in  1  reset; synchronous, active-high.
- I_VSYNC, I_HSYNC, I_DE  in  1 each  raw sync and data-enable inputs.
- O_DE  out  1  I_DE delayed 2 clocks, aligned with O_PIXEL_COLUMN/O_PIXEL_ROW.
- O_PIXEL_COLUMN  out  10  active pixel index in the line.
- O_PIXEL_ROW  out  9  active line index in the frame.
- O_FRAME_START  out  1  one-clock pulse on the VS leading edge.
- O_LINE_START  out  1  one-clock pulse on the HS leading edge.
- O_HTOTAL, O_HACT, O_VTOTAL, O_VACT  out  12 each  last measured geometry.
- O_LOCKED  out  1  geometry verified against the parameters.
- O_ERR  out  1  one-clock pulse on loss of lock or counter saturation.

## Operation
- Stage 1 registers the raw inputs and XORs each sync with its inverted POL, so internal syncs are active-high. Stage 2 performs edge detection using the previous stage-1 value.
- h_cnt clears on an HS leading edge, otherwise increments and saturates at 4095. On each HS leading edge after the first, O_HTOTAL <= h_cnt+1.
- hact_cnt counts DE-high clocks. On the DE falling edge, O_HACT <= hact_cnt and hact_cnt clears.
- v_cnt counts HS leading edges. On a VS leading edge, O_VTOTAL <= v_cnt and v_cnt clears.
- vact_cnt counts DE rising edges. On a VS leading edge, O_VACT <= vact_cnt and vact_cnt clears.
- Column clears at DE rising and increments while DE is high. It wraps at 1023 and does not saturate.
- Row clears on a VS edge, increments on each DE rising edge except the first of the frame, and wraps at 511.
- "Match" means all four measurements equal the corresponding parameter.
- FSM states:
  - SEARCH → MEASURE on the first VS edge.
  - MEASURE → VERIFY on the next VS edge if matched, otherwise → SEARCH.
  - VERIFY → LOCKED on the next VS edge if matched, otherwise → SEARCH.
  - LOCKED stays LOCKED while each VS edge matches. On a mismatch it goes → SEARCH and pulses O_ERR.
- Comparisons use the values latched on the same VS edge (a combinational compare of the next values).
- O_LOCKED = (state == LOCKED).
- Saturation of h_cnt (HS missing) in any state forces SEARCH and gives one O_ERR pulse per saturation event. v_cnt saturates at 4095 silently.
- Simultaneous VS and HS edges: the line is counted into the frame that is ending, then v_cnt clears (the clear wins).
- DE high across an HS edge: hact_cnt keeps counting. This results in a mismatch and no lock.

## Timing
- Reset values: all outputs 0, state = SEARCH, all counters 0, edge history 0. A reset mid-frame discards partial measurements.
- Latency is 2 clocks from input to O_DE, O_PIXEL_*, O_FRAME_START and O_LINE_START.
- Measurement outputs update 1 clock after the edge pulse is visible at stage 2.
- O_LOCKED rises in the clock after the third VS edge following reset with valid timing (SEARCH→MEASURE→VERIFY→LOCKED).
- No handshakes. All outputs are registered.

## Structure
- Shared package `video_timing_pkg`: the FSM state encoding (SEARCH=0, MEASURE=1, VERIFY=2, LOCKED=3), CNT_W=12, COL_W=10, ROW_W=9 and the VGA default constants. The output timing generator reuses these.
- One sub-module, `sync_edge_det`: a polarity-normalizing register plus a rising-edge pulse. Instantiate it three times, for HS, VS and DE; the falling edge of DE is derived in the parent.

## Test plan
- Nominal 640x480@800x525, all polarities 1: O_LOCKED rises after the 3rd VS edge. O_HTOTAL=800, O_HACT=640, O_VTOTAL=525, O_VACT=480. The last active pixel shows col=639, row=479.
- HACT=639 stimulus: no lock for 5 frames, state toggles SEARCH/MEASURE, O_ERR stays 0.
- Locked, then one frame with VTOTAL=524: O_LOCKED falls at that VS edge and O_ERR pulses once. Lock is regained 2 frames after timing is restored.
- HSYNC held low for 5000 clocks while locked: O_HTOTAL unchanged, h_cnt saturates at 4095, a single O_ERR pulse, O_LOCKED=0.
- I_RST asserted for 1 clock mid-line while locked: all outputs 0 next clock. The first O_FRAME_START follows the next VS edge, and re-lock takes 3 VS edges.
- HS_POL=0, VS_POL=0 with inverted stimulus: results identical to the nominal case.
